f_fetch_queue: RTL

Parametrised instruction-fetch stage: holds the fetch PC, reads a combinational instruction memory, and buffers fetched words in a DEPTH-entry FIFO toward the D stage with a valid/ready handshake. It sits in the F stage. It supports exception entry (`req`), exception return (`eret`), and D-stage branch/jump redirects. Every redirect flushes the queue. It replaces the plain PC register with a decoupled prefetcher.

---
 rtl/f_fetch_queue.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/f_fetch_queue.sv
// rtl/f_fetch_queue.sv - decoupled instruction-fetch stage with a DEPTH-entry prefetch queue
//
// Holds the fetch PC, reads a combinational instruction memory and buffers
// fetched words {pc, instr, adel} toward the D stage with a valid/ready
// handshake. req / eret / redirect (in that priority) reload the fetch PC
// and flush the queue.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   - with an empty queue and no redirect, the current fetch word
//               drives out_* combinationally (zero-cycle fetch-to-output)
//   undefined - out_* comes only from the queue head (one-cycle latency)
//
// Ports:
//   clk_i, reset_i          clock (rising edge), asynchronous active-high reset
//   req_i                   exception entry, fetch restarts at EXC_PC
//   eret_i, epc_i           exception return, fetch restarts at epc_i
//   redirect_i, redirect_pc_i  D-stage branch/jump, fetch restarts at redirect_pc_i
//   imem_addr_o             instruction memory address (= fetch_pc_o)
//   imem_rdata_i            combinational instruction memory read data
//   out_valid_o, out_ready_i   head handshake toward D
//   out_pc_o, out_instr_o, out_adel_o  head entry (all zero when empty)
//   fetch_pc_o              current fetch PC
module f_fetch_queue #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_3000,
    parameter logic [ADDR_W-1:0]  EXC_PC   = 32'h0000_4180,
    parameter logic [ADDR_W-1:0]  IM_BASE  = 32'h0000_3000,
    parameter logic [ADDR_W-1:0]  IM_END   = 32'h0000_6FFF,
    parameter int                 DEPTH    = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic              eret_i,
    input  logic [ADDR_W-1:0] epc_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [ADDR_W-1:0] imem_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [ADDR_W-1:0] out_instr_o,
    output logic              out_adel_o,
    output logic [ADDR_W-1:0] fetch_pc_o
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [ADDR_W-1:0] instr_mem [DEPTH];
    logic              adel_mem  [DEPTH];

    logic              fetch_adel;
    logic [ADDR_W-1:0] fetch_instr;
    logic              flush, q_valid, q_pop, push, advance;
    logic              bypass, byp_take;

    // Fetch word and handshake decisions
    always_comb begin
        fetch_adel  = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q < IM_BASE) || (fetch_pc_q > IM_END);
        fetch_instr = fetch_adel ? '0 : imem_rdata_i;
        flush       = req_i || eret_i || redirect_i;
        q_valid     = (count_q != '0);
        // A flush discards any same-cycle pop, so the pop only matters without flush.
        q_pop       = q_valid && out_ready_i;
`ifdef FETCH_BYPASS_EN
        bypass      = !q_valid && !flush;
        byp_take    = bypass && out_ready_i;
`else
        bypass      = 1'b0;
        byp_take    = 1'b0;
`endif
        // A word consumed straight through the bypass never enters the queue.
        push        = !flush && !byp_take && ((count_q < FULL_CNT) || q_pop);
        advance     = push || byp_take;
    end

    // Next-state
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (req_i)
            fetch_pc_d = EXC_PC;
        else if (eret_i)
            fetch_pc_d = epc_i;
        else if (redirect_i)
            fetch_pc_d = redirect_pc_i;
        else if (advance)
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (q_pop)
                head_d = head_q + 1'b1;
            if (push)
                tail_d = tail_q + 1'b1;
            case ({push, q_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Entry storage needs no reset: it is only visible while count_q covers it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[tail_q]    <= fetch_pc_q;
            instr_mem[tail_q] <= fetch_instr;
            adel_mem[tail_q]  <= fetch_adel;
        end
    end

    // Outputs
    always_comb begin
        imem_addr_o = fetch_pc_q;
        fetch_pc_o  = fetch_pc_q;
        out_valid_o = 1'b0;
        out_pc_o    = '0;
        out_instr_o = '0;
        out_adel_o  = 1'b0;
        if (bypass) begin
            out_valid_o = 1'b1;
            out_pc_o    = fetch_pc_q;
            out_instr_o = fetch_instr;
            out_adel_o  = fetch_adel;
        end else if (q_valid) begin
            out_valid_o = 1'b1;
            out_pc_o    = pc_mem[head_q];
            out_instr_o = instr_mem[head_q];
            out_adel_o  = adel_mem[head_q];
        end
    end

endmodule
